// File: rtl/corr_seq_ctrl.sv
// corr_seq_ctrl: run sequencer for one correlator core.
// Clears the core, loads its control register, then counts a window of samples.
// At the end of the window it snapshots the five 64-bit sums and streams them
// out as ten 32-bit words over a valid/ready handshake.
//
// Ports:
//   sys_clk, rst_n         clock, async active-low reset
//   start, abort           run command / run termination
//   n_samples, cfg_word    run length and core control word (latched on start)
//   sample_valid           one strobe per accumulated sample
//   corr_reset, we, cr_out core clear, control write strobe, control data
//   sr_in                  core status, bit0 = config acknowledged
//   sum_*                  core accumulators
//   rd_data/valid/ready    readout stream, rd_last marks word 9
//   busy, done, state_o    run status
module corr_seq_ctrl #(
    parameter int CNT_W      = 32,
    parameter int CLR_CYCLES = 4
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_samples,
    input  logic [31:0]      cfg_word,
    input  logic             sample_valid,
    output logic             corr_reset,
    output logic             we,
    output logic [31:0]      cr_out,
    input  logic [31:0]      sr_in,
    input  logic [63:0]      sum_x_2,
    input  logic [63:0]      sum_y_2,
    input  logic [63:0]      sum_xy,
    input  logic [63:0]      sum_xy90,
    input  logic [63:0]      sum_y90_2,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rd_last,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_CONFIG = 3'd2,
        S_ACK    = 3'd3,
        S_INTEG  = 3'd4,
        S_SNAP   = 3'd5,
        S_READ   = 3'd6,
        S_ABORT  = 3'd7
    } state_t;

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    state_t           state;
    logic [CLR_W-1:0] clr_cnt;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] smp_cnt;
    logic [31:0]      cfg_lat;
    logic [319:0]     snap_buf;
    logic [3:0]       rd_idx;

    // Only the acknowledge bit of the status register is used.
    logic unused_sr;
    assign unused_sr = ^sr_in[31:1];

    assign state_o = state;

    // Word i of the snapshot, high half of each sum first.
    function automatic logic [31:0] word_sel(
        input logic [319:0] b,
        input logic [3:0]   i
    );
        logic [31:0] w;
        w = '0;
        unique case (i)
            4'd0:    w = b[319:288];
            4'd1:    w = b[287:256];
            4'd2:    w = b[255:224];
            4'd3:    w = b[223:192];
            4'd4:    w = b[191:160];
            4'd5:    w = b[159:128];
            4'd6:    w = b[127:96];
            4'd7:    w = b[95:64];
            4'd8:    w = b[63:32];
            4'd9:    w = b[31:0];
            default: w = '0;
        endcase
        return w;
    endfunction

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            clr_cnt    <= '0;
            n_lat      <= '0;
            smp_cnt    <= '0;
            cfg_lat    <= '0;
            snap_buf   <= '0;
            rd_idx     <= '0;
            corr_reset <= 1'b0;
            we         <= 1'b0;
            cr_out     <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort wins over every other transition once a run is active.
            if (abort && (state != S_IDLE)) begin
                state      <= S_ABORT;
                corr_reset <= 1'b1;
                we         <= 1'b0;
                rd_valid   <= 1'b0;
                rd_last    <= 1'b0;
                busy       <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            n_lat      <= n_samples;
                            cfg_lat    <= cfg_word;
                            clr_cnt    <= '0;
                            corr_reset <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_CLEAR;
                        end
                    end
                    S_CLEAR: begin
                        if (clr_cnt == CLR_LAST) begin
                            corr_reset <= 1'b0;
                            we         <= 1'b1;
                            cr_out     <= cfg_lat;
                            state      <= S_CONFIG;
                        end else begin
                            clr_cnt <= clr_cnt + CLR_W'(1);
                        end
                    end
                    S_CONFIG: begin
                        we    <= 1'b0;
                        state <= S_ACK;
                    end
                    S_ACK: begin
                        if (sr_in[0]) begin
                            smp_cnt <= '0;
                            state   <= S_INTEG;
                        end
                    end
                    S_INTEG: begin
                        // A zero-length window closes without any strobe.
                        if (n_lat == '0) begin
                            state <= S_SNAP;
                        end else if (sample_valid) begin
                            smp_cnt <= smp_cnt + CNT_W'(1);
                            if (smp_cnt + CNT_W'(1) == n_lat) begin
                                state <= S_SNAP;
                            end
                        end
                    end
                    S_SNAP: begin
                        snap_buf <= {sum_x_2, sum_y_2, sum_xy,
                                     sum_xy90, sum_y90_2};
                        // Word 0 comes straight from the sum being latched.
                        rd_data  <= sum_x_2[63:32];
                        rd_idx   <= '0;
                        rd_valid <= 1'b1;
                        rd_last  <= 1'b0;
                        state    <= S_READ;
                    end
                    S_READ: begin
                        if (rd_ready) begin
                            if (rd_idx == 4'd9) begin
                                rd_valid <= 1'b0;
                                rd_last  <= 1'b0;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                rd_idx  <= rd_idx + 4'd1;
                                rd_data <= word_sel(snap_buf,
                                                    rd_idx + 4'd1);
                                rd_last <= (rd_idx == 4'd8);
                            end
                        end
                    end
                    S_ABORT: begin
                        corr_reset <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_corr_seq_ctrl.sv
// tb_corr_seq_ctrl: directed and randomized runs of corr_seq_ctrl.
// Expected timing and readout words come from a run-level model in the bench.
module tb_corr_seq_ctrl;

    localparam int CLR = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] n_samples = '0;
    logic [31:0] cfg_word = '0;
    logic        sample_valid = 1'b0;
    logic        corr_reset;
    logic        we;
    logic [31:0] cr_out;
    logic [31:0] sr_in = '0;
    logic [63:0] sums [5];
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        rd_last;
    logic        busy;
    logic        done;
    logic [2:0]  state_o;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    corr_seq_ctrl #(.CNT_W(32), .CLR_CYCLES(CLR)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .n_samples   (n_samples),
        .cfg_word    (cfg_word),
        .sample_valid(sample_valid),
        .corr_reset  (corr_reset),
        .we          (we),
        .cr_out      (cr_out),
        .sr_in       (sr_in),
        .sum_x_2     (sums[0]),
        .sum_y_2     (sums[1]),
        .sum_xy      (sums[2]),
        .sum_xy90    (sums[3]),
        .sum_y90_2   (sums[4]),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_last     (rd_last),
        .busy        (busy),
        .done        (done),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge sys_clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"},
            {58'd0, corr_reset, we, rd_valid, rd_last, busy, done}, 64'd0);
        chk({tag, "_state"}, {61'd0, state_o}, 64'd0);
        chk({tag, "_cr_out"}, {32'd0, cr_out}, 64'd0);
        chk({tag, "_rd_data"}, {32'd0, rd_data}, 64'd0);
    endtask

    // rdy_mode: 0 always ready, 1 three-cycle stall at word 4, 2 random.
    // abort_word < 0 means no abort during readout.
    task automatic do_run(input logic [31:0] n, input logic [31:0] cfg,
                          input int ack_d, input int rdy_mode,
                          input int abort_word, input bit rst_integ,
                          input bit chg_sums, input bit busy_start);
        logic [31:0] w [10];
        int m;
        int idx;
        int guard;
        int stall;
        bit first_integ;

        tick;
        chk("idle_state", {61'd0, state_o}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        start = 1'b1;
        n_samples = n;
        cfg_word = cfg;
        sr_in = 32'd0;

        for (int i = 0; i < CLR; i++) begin
            tick;
            start = 1'b0;
            n_samples = $urandom;
            cfg_word = $urandom;
            sample_valid = 1'($urandom);
            chk("clr_state", {61'd0, state_o}, 64'd1);
            chk("clr_corr_reset", {63'd0, corr_reset}, 64'd1);
            chk("clr_we", {63'd0, we}, 64'd0);
            chk("clr_busy", {63'd0, busy}, 64'd1);
        end

        tick;
        chk("cfg_state", {61'd0, state_o}, 64'd2);
        chk("cfg_we", {63'd0, we}, 64'd1);
        chk("cfg_cr_out", {32'd0, cr_out}, {32'd0, cfg});
        chk("cfg_corr_reset", {63'd0, corr_reset}, 64'd0);

        for (int k = 0; k <= ack_d; k++) begin
            tick;
            chk("ack_state", {61'd0, state_o}, 64'd3);
            chk("ack_we", {63'd0, we}, 64'd0);
            chk("ack_cr_hold", {32'd0, cr_out}, {32'd0, cfg});
            sample_valid = 1'($urandom);
            start = busy_start ? 1'($urandom) : 1'b0;
            if (k == ack_d) sr_in = 32'hFFFF_FFFF;
        end

        m = 0;
        guard = 0;
        first_integ = 1'b1;
        while (1) begin
            tick;
            chk("integ_state", {61'd0, state_o}, 64'd4);
            if (rst_integ && first_integ) begin
                #2 rst_n = 1'b0;
                #1 chk_zero("async_rst");
                tick;
                rst_n = 1'b1;
                start = 1'b0;
                sample_valid = 1'b0;
                sr_in = 32'd0;
                return;
            end
            first_integ = 1'b0;
            sample_valid = 1'($urandom);
            start = busy_start ? 1'($urandom) : 1'b0;
            if (n == 0) break;
            if (sample_valid) m++;
            if (m == n) break;
            guard++;
            if (guard > 300) begin
                chk("integ_timeout", 64'd0, 64'd1);
                return;
            end
        end

        tick;
        chk("snap_state", {61'd0, state_o}, 64'd5);
        chk("snap_rd_valid", {63'd0, rd_valid}, 64'd0);
        start = 1'b0;
        sample_valid = 1'b0;
        sr_in = 32'd0;
        for (int k = 0; k < 5; k++) begin
            w[2*k]   = sums[k][63:32];
            w[2*k+1] = sums[k][31:0];
        end

        idx = 0;
        guard = 0;
        stall = 0;
        while (1) begin
            tick;
            chk("rd_state", {61'd0, state_o}, 64'd6);
            chk("rd_valid", {63'd0, rd_valid}, 64'd1);
            chk("rd_data", {32'd0, rd_data}, {32'd0, w[idx]});
            chk("rd_last", {63'd0, rd_last}, {63'd0, (idx == 9)});
            chk("rd_done", {63'd0, done}, 64'd0);
            if (chg_sums) begin
                for (int k = 0; k < 5; k++) sums[k] = {$urandom, $urandom};
            end
            if (idx == abort_word) begin
                abort = 1'b1;
                rd_ready = 1'($urandom);
                tick;
                abort = 1'b0;
                chk("ab_state", {61'd0, state_o}, 64'd7);
                chk("ab_rd_valid", {63'd0, rd_valid}, 64'd0);
                chk("ab_rd_last", {63'd0, rd_last}, 64'd0);
                chk("ab_corr_reset", {63'd0, corr_reset}, 64'd1);
                chk("ab_done", {63'd0, done}, 64'd0);
                tick;
                chk("ab_idle", {61'd0, state_o}, 64'd0);
                chk("ab_corr_off", {63'd0, corr_reset}, 64'd0);
                chk("ab_no_done", {63'd0, done}, 64'd0);
                chk("ab_busy", {63'd0, busy}, 64'd0);
                rd_ready = 1'b0;
                return;
            end
            case (rdy_mode)
                0: rd_ready = 1'b1;
                1: begin
                    if (idx == 4 && stall < 3) begin
                        rd_ready = 1'b0;
                        stall++;
                    end else begin
                        rd_ready = 1'b1;
                    end
                end
                default: rd_ready = 1'($urandom);
            endcase
            if (rd_ready) begin
                if (idx == 9) break;
                idx++;
            end
            guard++;
            if (guard > 300) begin
                chk("rd_timeout", 64'd0, 64'd1);
                return;
            end
        end

        tick;
        rd_ready = 1'b0;
        chk("end_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("end_rd_last", {63'd0, rd_last}, 64'd0);
        chk("end_done", {63'd0, done}, 64'd1);
        chk("end_state", {61'd0, state_o}, 64'd0);
        chk("end_busy", {63'd0, busy}, 64'd0);
        tick;
        chk("done_pulse", {63'd0, done}, 64'd0);
    endtask

    initial begin
        for (int k = 0; k < 5; k++) sums[k] = 64'hAAFF_00FF_00FF_0081;
        #2 chk_zero("reset");
        tick;
        rst_n = 1'b1;

        // abort alone and start+abort together in IDLE do nothing
        abort = 1'b1;
        tick;
        chk("idle_abort_state", {61'd0, state_o}, 64'd0);
        chk("idle_abort_cr", {63'd0, corr_reset}, 64'd0);
        start = 1'b1;
        tick;
        chk("start_abort_state", {61'd0, state_o}, 64'd0);
        chk("start_abort_busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        abort = 1'b0;

        // basic run
        do_run(32'd3, 32'h0000_0005, 0, 0, -1, 1'b0, 1'b0, 1'b0);

        // backpressure at word 4, distinct last sum, inputs churn in READ
        for (int k = 0; k < 4; k++) sums[k] = 64'hAAFF_00FF_00FF_0081;
        sums[4] = 64'h1122_3344_5566_7788;
        do_run(32'd3, 32'h0000_0005, 0, 1, -1, 1'b0, 1'b1, 1'b0);

        // long ACK stall
        for (int k = 0; k < 5; k++) sums[k] = {$urandom, $urandom};
        do_run(32'($urandom_range(1, 6)), $urandom, 20, 0, -1,
               1'b0, 1'b0, 1'b0);

        // zero-length window
        for (int k = 0; k < 5; k++) sums[k] = {$urandom, $urandom};
        do_run(32'd0, $urandom, 1, 2, -1, 1'b0, 1'b0, 1'b0);

        // abort at word 6, then a normal run
        for (int k = 0; k < 5; k++) sums[k] = {$urandom, $urandom};
        do_run(32'd2, $urandom, 0, 0, 6, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) sums[k] = {$urandom, $urandom};
        do_run(32'd2, $urandom, 0, 0, -1, 1'b0, 1'b0, 1'b0);

        // async reset mid-INTEG, then a run with start pulses while busy
        do_run(32'd5, 32'hDEAD_BEEF, 0, 0, -1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) sums[k] = {$urandom, $urandom};
        do_run(32'd4, $urandom, 2, 2, -1, 1'b0, 1'b0, 1'b1);

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 5; k++) sums[k] = {$urandom, $urandom};
            do_run(32'($urandom_range(0, 6)), $urandom,
                   int'($urandom_range(0, 3)), 2, -1, 1'b0, 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
